led_ctrl_input: RTL and testbench
=================================

Name: led_ctrl_input

Overview:
- Input-side front end for the 16-bit LED shifter datapath. It conditions two raw pushbuttons into the stable `en` and `dir` control levels that the shifter consumes.
- It also generates the shift-step strobe, so the shifter advances on a single-cycle enable instead of a divided clock.
- It sits between the board buttons and the LED pattern logic, all in one clock domain.

Parameters:
- DEB_CYCLES, 16, consecutive stable samples required to accept a button level change (board build overrides to 1000000).
- TICK_DIV, 8, clk cycles per `step` pulse period. Legal range is 2 to 2^24.
- HOLD_CYCLES, 64, press duration that triggers a hold-clear (used only when the optional feature is compiled in).

Ports:
- clk  input  1  system clock; every register is clocked on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_en  input  1  raw enable pushbutton, active-high, may bounce, asynchronous to clk.
- btn_dir  input  1  raw direction pushbutton, active-high, may bounce, asynchronous to clk.
- en  output  1  enable level; toggles once per accepted btn_en press.
- dir  output  1  direction level; toggles once per accepted btn_dir press. 1 = rotate left, 0 = rotate right.
- step  output  1  one-cycle strobe, emitted every TICK_DIV cycles while en=1.
- dir_chg  output  1  one-cycle strobe in the cycle that `dir` toggles.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: en=0, dir=0, step=0, dir_chg=0.
  - Internals: synchronizers to 0, debounce counters to 0, tick counter to 0, both button FSMs to IDLE.
  - Release of reset is synchronous. No output changes in the first cycle after release.
- Synchronizer: each button passes through a 2-flop synchronizer. The sampled value is the second flop's output.
- Per-button FSM (identical instances):
  - States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: sampled=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT:
    - sampled=0 -> IDLE.
    - Otherwise the counter increments. When it reaches DEB_CYCLES-1 -> HELD, and a one-cycle `press` pulse fires on that transition.
  - HELD: sampled=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT:
    - sampled=1 -> HELD.
    - Otherwise the counter increments. When it reaches DEB_CYCLES-1 -> IDLE.
  - Counter width: clog2(DEB_CYCLES)+1 bits. The counter saturates and never wraps.
- Latency: `en` or `dir` toggles exactly 2 + DEB_CYCLES cycles after a clean rising button edge is first presented at the synchronizer input.
- Toggle logic:
  - A `press` from the btn_en FSM inverts `en` on the next edge.
  - A `press` from the btn_dir FSM inverts `dir` on the next edge, and dir_chg=1 for that same cycle.
  - Simultaneous presses: both toggle in the same cycle, independently.
- Tick generator:
  - While en=1, the counter counts 0..TICK_DIV-1 and wraps to 0. step=1 in the cycle the counter equals TICK_DIV-1.
  - While en=0, the counter holds at 0 and step=0.
  - When en goes 0->1, the first step occurs TICK_DIV cycles after the en transition.
  - When en goes 1->0 in the same cycle a step would fire, step is suppressed.
- Bounce handling: any glitch shorter than DEB_CYCLES produces no toggle. A held button produces exactly one toggle.
- Reset asserted mid-debounce or mid-hold: all state is discarded. A button still held after reset release must go through PRESS_WAIT again and then toggles.

Optional Feature:
- Macro: LED_CTRL_HOLD_CLEAR_EN.
- Defined:
  - In HELD, the btn_en FSM keeps counting. When the hold count reaches HOLD_CYCLES-1 (measured from entry to HELD), en is forced to 0, dir to 0, and the tick counter to 0.
  - The hold-clear fires once per press. Release behaves normally afterward.
  - The press toggle at HELD entry still happens first.
- Undefined: no hold counter is implemented. Holding the button has no effect beyond the single toggle.

Test Plan:
- Reset, then no button activity for 200 cycles -> en=0, dir=0, step never asserted, dir_chg never asserted.
- btn_en held high for 40 cycles (DEB_CYCLES=16) -> en rises exactly 18 cycles after the edge. step then pulses every 8 cycles: first pulse 8 cycles after en rises, 4 pulses by cycle 50.
- btn_dir bouncing with 5 toggles of 3 cycles each, then stable high for 20 cycles -> exactly one dir toggle 0->1, and dir_chg high for exactly 1 cycle.
- btn_en and btn_dir rising in the same cycle, both clean for 20 cycles -> en and dir toggle in the same cycle.
- With en=1, a second btn_en press -> en falls, step stays 0 afterward, and the tick counter reads 0.
- Reset pulled low while btn_en is in PRESS_WAIT at count 10 -> no toggle. With the button still held after release, en rises 18 cycles after reset release.
- With LED_CTRL_HOLD_CLEAR_EN defined and btn_en held 100 cycles from a state of en=0, dir=1:
  - en rises after 18 cycles.
  - At 64 cycles after en rises, en=0 and dir=0.
  - No further change until release.

Source files
------------

// File: rtl/led_ctrl_input_if.sv
// Button/control bundle between the board pushbuttons and the LED shifter front end.
// master = button/shifter side, slave = led_ctrl_input.
interface led_ctrl_input_if;
  logic btn_en;
  logic btn_dir;
  logic en;
  logic dir;
  logic step;
  logic dir_chg;

  modport master (output btn_en, btn_dir, input en, dir, step, dir_chg);
  modport slave  (input btn_en, btn_dir, output en, dir, step, dir_chg);
endinterface

// File: rtl/led_ctrl_input.sv
// Debounces the en/dir pushbuttons into toggled control levels and generates the shifter step strobe.
// Optional hold-to-clear on btn_en is compiled in with `define LED_CTRL_HOLD_CLEAR_EN.
module led_ctrl_input #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned TICK_DIV    = 8,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  led_ctrl_input_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_e;

  localparam int unsigned   CW        = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam int unsigned   TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (DEB_CYCLES < 1 || TICK_DIV < 2 || HOLD_CYCLES < 1) begin : g_param_chk
    $error("led_ctrl_input: illegal parameter value");
  end

  logic [1:0]    w_btn;
  logic [1:0]    r_sync0;
  logic [1:0]    r_sync1;
  logic [1:0]    w_press;
  logic          r_en;
  logic          r_dir;
  logic          r_step;
  logic          r_dir_chg;
  logic [TW-1:0] r_tick;
  logic          w_en_nxt;
  logic          w_dir_nxt;
  logic          w_run;

  assign w_btn = {bus.btn_dir, bus.btn_en};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= w_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Bit 0 = btn_en, bit 1 = btn_dir; press fires combinationally on PRESS_WAIT->HELD.
  for (genvar g = 0; g < 2; g++) begin : g_deb
    deb_state_e    r_state;
    deb_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_smp;
    logic          w_press_g;

    assign w_smp     = r_sync1[g];
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press_g   = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_smp) begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_smp) begin
            w_state_nxt = IDLE;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = HELD;
            w_press_g   = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        HELD: begin
          if (!w_smp) begin
            w_state_nxt = RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_smp) begin
            w_state_nxt = HELD;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    assign w_press[g] = w_press_g;
  end

`ifdef LED_CTRL_HOLD_CLEAR_EN
  localparam int unsigned   HW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] r_hold;
  logic          w_hold_clr;

  // Kept through RELEASE_WAIT bounces and saturating past HOLD_LAST, so the clear fires once per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (g_deb[0].r_state == HELD) begin
      if (r_hold != '1) r_hold <= r_hold + 1'b1;
    end else if (g_deb[0].r_state != RELEASE_WAIT) begin
      r_hold <= '0;
    end
  end

  assign w_hold_clr = (g_deb[0].r_state == HELD) && (r_hold == HOLD_LAST);

  always_comb begin
    w_en_nxt  = r_en ^ w_press[0];
    w_dir_nxt = r_dir ^ w_press[1];
    if (w_hold_clr) begin
      w_en_nxt  = 1'b0;
      w_dir_nxt = 1'b0;
    end
  end
`else
  always_comb begin
    w_en_nxt  = r_en ^ w_press[0];
    w_dir_nxt = r_dir ^ w_press[1];
  end
`endif

  // Counting needs en both now and next, so a step landing on the en 1->0 edge is dropped.
  assign w_run = r_en & w_en_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en      <= 1'b0;
      r_dir     <= 1'b0;
      r_dir_chg <= 1'b0;
      r_step    <= 1'b0;
      r_tick    <= '0;
    end else begin
      r_en      <= w_en_nxt;
      r_dir     <= w_dir_nxt;
      r_dir_chg <= w_dir_nxt ^ r_dir;
      r_step    <= w_run && (r_tick == TICK_LAST);
      if (!w_run || r_tick == TICK_LAST) r_tick <= '0;
      else                               r_tick <= r_tick + 1'b1;
    end
  end

  assign bus.en      = r_en;
  assign bus.dir     = r_dir;
  assign bus.step    = r_step;
  assign bus.dir_chg = r_dir_chg;

endmodule

// File: tb/tb_led_ctrl_input.sv
// Self-checking bench for led_ctrl_input: table-driven segments with a scoreboard queue,
// plus cycle-exact sequences for latency, step suppression, simultaneous presses, hold and reset.
module tb_led_ctrl_input;

  typedef struct {
    logic        b_en;
    logic        b_dir;
    int unsigned cyc;
    logic        e_en;
    logic        e_dir;
    int unsigned e_step;
    int unsigned e_dchg;
  } vec_t;

  typedef struct {
    logic        en;
    logic        dir;
    int unsigned step;
    int unsigned dchg;
  } obs_t;

`ifdef LED_CTRL_HOLD_CLEAR_EN
  localparam logic HOLD_ON = 1'b1;
`else
  localparam logic HOLD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  obs_t exp_q[$];

  led_ctrl_input_if bus ();

  led_ctrl_input #(
    .DEB_CYCLES (16),
    .TICK_DIV   (8),
    .HOLD_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bus.btn_en  = 1'b0;
    bus.btn_dir = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    vec_t        vecs[$];
    obs_t        e;
    int unsigned ns;
    int unsigned nd;
    bit          seen;

    bus.btn_en  = 1'b0;
    bus.btn_dir = 1'b0;
    repeat (3) cyc();
    chk("reset_outputs", {bus.en, bus.dir, bus.step, bus.dir_chg}, 4'b0000);
    rst = 1'b1;

    // {btn_en, btn_dir, cycles, en, dir, step pulses, dir_chg pulses}
    vecs.push_back('{1'b0, 1'b0, 200, 1'b0, 1'b0, 0, 0});
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{1'b0, 1'b1, 3, 1'b0, 1'b0, 0, 0});
      vecs.push_back('{1'b0, 1'b0, 3, 1'b0, 1'b0, 0, 0});
    end
    vecs.push_back('{1'b0, 1'b1, 20, 1'b0, 1'b1, 0, 1});
    vecs.push_back('{1'b0, 1'b0, 30, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 20, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{1'b0, 1'b0, 40, 1'b1, 1'b0, 5, 0});
    vecs.push_back('{1'b1, 1'b0, 30, 1'b0, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 1'b0, 30, 1'b0, 1'b0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      bus.btn_en  = vecs[i].b_en;
      bus.btn_dir = vecs[i].b_dir;
      exp_q.push_back('{vecs[i].e_en, vecs[i].e_dir, vecs[i].e_step, vecs[i].e_dchg});
      ns = 0;
      nd = 0;
      repeat (vecs[i].cyc) begin
        cyc();
        if (bus.step)    ns++;
        if (bus.dir_chg) nd++;
      end
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_en", i),   bus.en,  e.en);
      chk($sformatf("vec%0d_dir", i),  bus.dir, e.dir);
      chk($sformatf("vec%0d_step", i), ns,      e.step);
      chk($sformatf("vec%0d_dchg", i), nd,      e.dchg);
    end

    // Exact en latency from the capturing edge and first step position.
    bus.btn_en = 1'b1;
    cyc();
    for (int c = 1; c <= 27; c++) begin
      cyc();
      if (c == 17) chk("lat_en_before", bus.en, 1'b0);
      if (c == 18) chk("lat_en_rise", bus.en, 1'b1);
      if (c == 25) chk("first_step_early", bus.step, 1'b0);
      if (c == 26) chk("first_step", bus.step, 1'b1);
      if (c == 27) chk("first_step_width", bus.step, 1'b0);
    end
    idle(25);

    // Press timed so en falls on the edge where a step would otherwise fire.
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc();
      if (bus.step) seen = 1'b1;
    end
    chk("step_seen", seen, 1'b1);
    repeat (5) cyc();
    bus.btn_en = 1'b1;
    cyc();
    for (int c = 1; c <= 18; c++) begin
      cyc();
      if (c == 10) chk("step_before_off", bus.step, 1'b1);
      if (c == 17) chk("en_before_off", bus.en, 1'b1);
      if (c == 18) begin
        chk("en_off", bus.en, 1'b0);
        chk("step_suppressed", bus.step, 1'b0);
      end
    end
    ns = 0;
    repeat (20) begin
      cyc();
      if (bus.step) ns++;
    end
    chk("no_step_after_off", ns, 0);
    idle(25);

    // Simultaneous presses toggle both levels on the same edge.
    bus.btn_en  = 1'b1;
    bus.btn_dir = 1'b1;
    cyc();
    for (int c = 1; c <= 19; c++) begin
      cyc();
      if (c == 17) chk("sim_before", {bus.en, bus.dir, bus.dir_chg}, 3'b000);
      if (c == 18) chk("sim_toggle", {bus.en, bus.dir, bus.dir_chg}, 3'b111);
      if (c == 19) chk("sim_dchg_width", {bus.en, bus.dir, bus.dir_chg}, 3'b110);
    end
    idle(25);
    bus.btn_en = 1'b1;
    repeat (22) cyc();
    idle(25);
    chk("hold_precond", {bus.en, bus.dir}, 2'b01);

    // Long hold of btn_en from en=0, dir=1.
    bus.btn_en = 1'b1;
    cyc();
    for (int c = 1; c <= 100; c++) begin
      cyc();
      if (c == 18)  chk("hold_en_rise", bus.en, 1'b1);
      if (c == 81)  chk("hold_before_clr", {bus.en, bus.dir}, 2'b11);
      if (c == 82)  chk("hold_at_clr", {bus.en, bus.dir}, {!HOLD_ON, !HOLD_ON});
      if (c == 100) chk("hold_end", {bus.en, bus.dir}, {!HOLD_ON, !HOLD_ON});
    end
    idle(25);

    // Reset while btn_en sits in PRESS_WAIT at count 10, button kept held.
    bus.btn_en = 1'b1;
    cyc();
    repeat (12) cyc();
    chk("pw_no_toggle", bus.en, !HOLD_ON);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {bus.en, bus.dir, bus.step, bus.dir_chg}, 4'b0000);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    for (int c = 1; c <= 18; c++) begin
      cyc();
      if (c == 17) chk("post_reset_en_before", bus.en, 1'b0);
      if (c == 18) chk("post_reset_en_rise", {bus.en, bus.dir}, 2'b10);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
